imem_responder: RTL

//  Instruction-memory responder at the far end of the fetch-address interface.

---
 rtl/imem_responder_if.sv | 32 +++
 rtl/imem_responder.sv | 100 ++++++++++
 2 files changed

// File: rtl/imem_responder_if.sv
// imem_responder_if
//  Fetch-request / response and program-load signals between the fetch path
//  (or the boot loader / testbench) and the instruction-memory responder.
//  master: requester side (drives req_* and ld_* controls).
//  slave : responder side (drives rsp_*, busy, ld_ready).
interface imem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_valid;
  logic                  busy;
  logic                  ld_start;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  ld_done;

  modport master (
    output req_addr, req_valid, ld_start, ld_valid, ld_addr, ld_data, ld_done,
    input  rsp_data, rsp_addr, rsp_valid, busy, ld_ready
  );

  modport slave (
    input  req_addr, req_valid, ld_start, ld_valid, ld_addr, ld_data, ld_done,
    output rsp_data, rsp_addr, rsp_valid, busy, ld_ready
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder
//  Instruction memory at the far end of the fetch-address interface. A fetch
//  issued in cycle N returns mem[req_addr] with the address echoed in N+1.
//  After reset the array is optionally filled with NOP_WORD (INIT), and a
//  program-load port (LOAD) writes words while fetches are dropped.
// Ports
//  clk, rst : clock (rising edge), asynchronous active-high reset
//  bus      : imem_responder_if.slave
//             req_addr/req_valid in, rsp_data/rsp_addr/rsp_valid out,
//             busy out (INIT or LOAD), ld_start/ld_valid/ld_addr/ld_data/
//             ld_done in, ld_ready out (LOAD only)
module imem_responder #(
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    DATA_WIDTH     = 24,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = '0
) (
  input  logic            clk,
  input  logic            rst,
  imem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_LOAD} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port, source selected by state (fill vs. program load)
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic                  busy_c, ld_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    we         = 1'b0;
    waddr      = bus.ld_addr;
    wdata      = bus.ld_data;
    rd_en      = 1'b0;
    busy_c     = 1'b1;
    ld_ready_c = 1'b0;
    case (state)
      S_INIT: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = NOP_WORD;
        // clr_cnt wraps to 0 on the last fill write, ready for the next reset
        if (clr_cnt == '1) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy_c = 1'b0;
        rd_en  = bus.req_valid;
        // a read in the same cycle as ld_start is still served
        if (bus.ld_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_ready_c = 1'b1;
        we         = bus.ld_valid;
        if (bus.ld_done) state_nxt = S_RUN;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  assign bus.busy     = busy_c;
  assign bus.ld_ready = ld_ready_c;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Response register; data/address hold when no read is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= NOP_WORD;
      bus.rsp_addr  <= '0;
    end else begin
      bus.rsp_valid <= rd_en;
      if (rd_en) begin
        bus.rsp_data <= mem[bus.req_addr];
        bus.rsp_addr <= bus.req_addr;
      end
    end
  end
endmodule
